// File: rtl/fft2d_unit_loader.sv
// Pops FFT samples from the IO FIFO and scatters them in order across the row-FFT units.
// Two-stage read pipeline (tag stage, data stage) gives a fixed 2-cycle read-to-write latency.
module fft2d_unit_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_UNITS = 32,
  parameter int unsigned UNIT_W    = 5,
  parameter int unsigned POINTS    = 32,
  parameter int unsigned PTS_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_cs,
  output logic                 fifo_rd_en,
  input  logic [DATA_W-1:0]    fifo_data,
  input  logic [NUM_UNITS-1:0] unit_ready,
  output logic                 unit_wr,
  output logic [UNIT_W-1:0]    unit_sel,
  output logic [PTS_W-1:0]     unit_addr,
  output logic [DATA_W-1:0]    unit_data,
  output logic [NUM_UNITS-1:0] unit_go,
  output logic                 busy,
  output logic                 done
);

  localparam logic [UNIT_W-1:0] LastUnit = UNIT_W'(NUM_UNITS - 1);
  localparam logic [PTS_W-1:0]  LastPt   = PTS_W'(POINTS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e                state_q, state_d;
  logic [UNIT_W-1:0]     cur_unit_q, cur_unit_d;
  logic [PTS_W-1:0]      cur_pt_q, cur_pt_d;
  logic                  busy_q, busy_d;
  logic                  rd_cs_q, rd_cs_d;
  logic                  done_q, done_d;
  logic                  rd_en;
  logic                  flush;

  logic                  s1_valid_q;
  logic [UNIT_W-1:0]     s1_unit_q;
  logic [PTS_W-1:0]      s1_pt_q;
  logic                  wr_q;
  logic [UNIT_W-1:0]     sel_q;
  logic [PTS_W-1:0]      addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [NUM_UNITS-1:0]  go_q, go_d;

  always_comb begin
    state_d    = state_q;
    cur_unit_d = cur_unit_q;
    cur_pt_d   = cur_pt_q;
    busy_d     = busy_q;
    rd_cs_d    = rd_cs_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StIssue;
          cur_unit_d = '0;
          cur_pt_d   = '0;
          busy_d     = 1'b1;
          rd_cs_d    = 1'b1;
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          rd_cs_d = 1'b0;
          flush   = 1'b1;
        end else begin
          rd_en = rd_cs_q & ~fifo_empty & unit_ready[cur_unit_q];
          if (rd_en) begin
            cur_pt_d = cur_pt_q + 1'b1;
            if (cur_pt_q == LastPt) begin
              cur_unit_d = cur_unit_q + 1'b1;
              if (cur_unit_q == LastUnit) begin
                state_d = StDrain;
              end
            end
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          rd_cs_d = 1'b0;
          flush   = 1'b1;
        end else if (!s1_valid_q && !wr_q && go_q[NUM_UNITS-1]) begin
          // Last unit's go is on the bus and nothing is left in flight.
          state_d = StFinish;
          busy_d  = 1'b0;
          rd_cs_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    go_d = '0;
    if (wr_q && (addr_q == LastPt)) begin
      go_d[sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cur_unit_q <= '0;
      cur_pt_q   <= '0;
      busy_q     <= 1'b0;
      rd_cs_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_unit_q <= cur_unit_d;
      cur_pt_q   <= cur_pt_d;
      busy_q     <= busy_d;
      rd_cs_q    <= rd_cs_d;
      done_q     <= done_d;
    end
  end

  // Stage 1 holds the tags while the FIFO produces the data one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_unit_q  <= '0;
      s1_pt_q    <= '0;
    end else begin
      s1_valid_q <= rd_en & ~flush;
      if (rd_en) begin
        s1_unit_q <= cur_unit_q;
        s1_pt_q   <= cur_pt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      go_q   <= '0;
    end else begin
      wr_q <= s1_valid_q & ~flush;
      go_q <= flush ? '0 : go_d;
      if (s1_valid_q) begin
        sel_q  <= s1_unit_q;
        addr_q <= s1_pt_q;
        data_q <= fifo_data;
      end
    end
  end

  assign fifo_rd_cs = rd_cs_q;
  assign fifo_rd_en = rd_en;
  assign unit_wr    = wr_q;
  assign unit_sel   = sel_q;
  assign unit_addr  = addr_q;
  assign unit_data  = data_q;
  assign unit_go    = go_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/fft2d_unit_loader.md
Name: fft2d_unit_loader

Overview:
- Sits directly downstream of the FFT2D IO FIFO stage.
- Pops samples from the FIFO over the shared data_for_units bus and distributes them, in order, to NUM_UNITS row-FFT units.
- Each unit receives POINTS consecutive samples. After a unit's last sample is written, the block pulses that unit's go strobe.
- A frame is NUM_UNITS*POINTS samples, started by a start pulse and ended by a done pulse.

Parameters:
- DATA_W, 32, sample width; matches the FFT data width.
- NUM_UNITS, 32, number of FFT units fed per frame.
- UNIT_W, 5, width of the unit index; equals log2(NUM_UNITS).
- POINTS, 32, samples per unit per frame.
- PTS_W, 5, width of the point index; equals log2(POINTS).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- abort  in  1  synchronous frame abort.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_cs  out  1  FIFO read chip select; high for the whole frame.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_data  in  DATA_W  FIFO read data (data_for_units bus); valid the cycle after fifo_rd_en.
- unit_ready  in  NUM_UNITS  per-unit "can accept a sample" flags.
- unit_wr  out  1  sample write strobe to the selected unit.
- unit_sel  out  UNIT_W  destination unit index for unit_wr.
- unit_addr  out  PTS_W  point index within the unit for unit_wr.
- unit_data  out  DATA_W  sample data for unit_wr.
- unit_go  out  NUM_UNITS  one-hot, one-cycle "unit fully loaded" pulse.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: fifo_rd_cs, fifo_rd_en, unit_wr, unit_sel, unit_addr, unit_data, unit_go, busy, done.
  - Counters cur_unit and cur_pt are 0; all pipeline valid bits are 0.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 moves to ISSUE next cycle; cur_unit and cur_pt are cleared.
  - busy and fifo_rd_cs are registered high from the ISSUE entry cycle.
- ISSUE (combinational read enable):
  - fifo_rd_en = fifo_rd_cs & ~fifo_empty & unit_ready[cur_unit] & ~abort.
  - Each cycle fifo_rd_en=1 advances cur_pt.
  - When cur_pt wraps from POINTS-1 to 0, cur_unit increments.
  - Issuing the last sample (cur_unit=NUM_UNITS-1, cur_pt=POINTS-1) moves the FSM to DRAIN.
- Stalls:
  - fifo_empty=1 or unit_ready[cur_unit]=0 holds fifo_rd_en low and freezes the counters.
  - No sample is ever dropped or duplicated.
- Read pipeline, with fifo_rd_en high in cycle N:
  - Cycle N: stage-1 register captures {valid, cur_unit, cur_pt}.
  - Cycle N+1: fifo_data is valid. Output registers capture fifo_data and the stage-1 tags.
  - Cycle N+2: unit_wr=1 with unit_data, unit_sel, unit_addr. Fixed read-to-write latency is 2 cycles.
  - Throughput is 1 sample/cycle when unstalled. Back-to-back writes may cross a unit boundary without a bubble.
- Unit completion:
  - unit_go[k] pulses for one cycle, in the cycle after the unit_wr with unit_sel=k and unit_addr=POINTS-1.
  - unit_go is one-hot or zero.
- DRAIN: waits until the pipeline is empty and the final unit_go has been issued, then moves to FINISH. fifo_rd_cs drops on the DRAIN→FINISH transition.
- FINISH:
  - done=1 for one cycle; busy falls in the same cycle.
  - The FSM returns to IDLE.
  - start is ignored in FINISH; the earliest new start is accepted in the next cycle.
- start while busy is ignored, with no effect on counters.
- abort=1 in ISSUE or DRAIN:
  - fifo_rd_en is forced 0 that cycle.
  - In-flight pipeline entries are discarded; no further unit_wr or unit_go.
  - Next cycle: IDLE with busy=0, fifo_rd_cs=0; done is not pulsed.
- Reset mid-frame: immediate return to the reset state. A sample already popped from the FIFO is lost; that is acceptable.
- Counter widths:
  - cur_pt wraps modulo POINTS and cur_unit modulo NUM_UNITS.
  - Both must be powers of two; non-power-of-two values are unsupported.

Test Plan:
- Fill FIFO with 1024 samples 0..1023, all unit_ready=1, start → 1024 unit_wr on consecutive cycles, first write 2 cycles after the first fifo_rd_en; sample v arrives at unit_sel=v/32, unit_addr=v%32; unit_go[k] one cycle after the write of sample 32k+31; done one cycle after unit_go[31].
- FIFO empty for cycles 10–19 mid-frame → fifo_rd_en low for those cycles, no gaps or duplicates in the write sequence, done delayed by exactly 10 cycles versus the unstalled run.
- unit_ready[3]=0 until 50 cycles after unit 2 completes → reads stop at sample 96 and resume afterwards; unit 3 receives data 96..127 with addr 0..31.
- Assert start while busy at sample 500 → no restart, counters unaffected; start in the FINISH cycle ignored, start one cycle later accepted.
- Abort after sample 200 is issued → no unit_wr after the abort cycle, done never asserts, busy=0 and fifo_rd_cs=0 next cycle.
- Drive reset=0 asynchronously mid-frame (between clock edges) → all outputs 0 immediately; after reset release the FSM is in IDLE and a fresh start runs a clean frame.
